gate_arbiter: RTL and testbench

Shares the single parking register manager (token check + parking-time registration) among `N_GATES` entry/exit gate requesters. Round-robin arbitration selects one gate, forwards its request, confirm and user token to the manager, and returns the manager's verdict to that gate only. Optionally times out a granted gate that never confirms. Sits between the gate front-ends and the register manager in the parking system top level.

---
 rtl/gate_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_gate_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one parking register manager among N_GATES gate requesters.
// Optional confirm timeout is compiled in when GATE_ARB_TIMEOUT_EN is defined.
module gate_arbiter #(
  parameter int N_GATES = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_GATES-1:0]     gate_req,
  input  logic [N_GATES-1:0]     gate_confirm,
  input  logic [3*N_GATES-1:0]   gate_token,
  input  logic                   mgr_valid,
  input  logic                   mgr_match,
  output logic [N_GATES-1:0]     gate_grant,
  output logic [N_GATES-1:0]     gate_done,
  output logic [N_GATES-1:0]     gate_ok,
  output logic [N_GATES-1:0]     gate_timeout,
  output logic                   mgr_request,
  output logic                   mgr_confirm,
  output logic [2:0]             mgr_user_token,
  output logic                   busy
);

  localparam int IW = (N_GATES > 1) ? $clog2(N_GATES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [2:0]      token_q, token_d;
  logic            ok_q, ok_d;
  logic            to_q, to_d;
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic [IW-1:0]   idx_inc;
  logic [N_GATES-1:0] idx_onehot;
  logic            timeout_hit;

  // Marker block only; TIMEOUT must stay within 1..255 for the 8-bit counter.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

  for (genvar gi = 0; gi < N_GATES; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_q == IW'(gi));
  end

  assign idx_inc = (idx_q == IW'(N_GATES - 1)) ? '0 : idx_q + IW'(1);

  // Search upward from ptr with wrap; the first requester found wins.
  always_comb begin
    int unsigned pos;
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    pos       = 0;
    for (int k = 0; k < N_GATES; k++) begin
      pos = 32'(ptr_q) + 32'(k);
      if (pos >= 32'(N_GATES)) pos = pos - 32'(N_GATES);
      if (!sel_found && gate_req[pos]) begin
        sel_found = 1'b1;
        sel_idx   = pos[IW-1:0];
      end
    end
  end

`ifdef GATE_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       first_q, first_d;

  // The first BUSY cycle only clears, so the release lands TIMEOUT+1 cycles after grant.
  always_comb begin
    cnt_d   = cnt_q;
    first_d = 1'b1;
    if (state_q == S_BUSY) begin
      first_d = 1'b0;
      if (first_q || gate_confirm[idx_q]) cnt_d = 8'd0;
      else if (cnt_q != 8'hFF)            cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  assign timeout_hit = (state_q == S_BUSY) && !first_q && !gate_confirm[idx_q] &&
                       (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      token_q <= 3'b000;
      ok_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      token_q <= token_d;
      ok_q    <= ok_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    token_d = token_q;
    ok_d    = ok_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          token_d = gate_token[3*sel_idx +: 3];
          ok_d    = 1'b0;
          to_d    = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Abort outranks a same-cycle verdict, which outranks the timeout.
        if (!gate_req[idx_q]) begin
          ptr_d   = idx_inc;
          state_d = S_IDLE;
        end else if (mgr_valid) begin
          ok_d    = mgr_match;
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          ok_d    = 1'b0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = idx_inc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gate_grant   = '0;
    gate_done    = '0;
    gate_ok      = '0;
    gate_timeout = '0;
    mgr_request  = 1'b0;
    mgr_confirm  = 1'b0;
    busy         = 1'b0;
    case (state_q)
      S_BUSY: begin
        gate_grant  = idx_onehot;
        mgr_request = 1'b1;
        mgr_confirm = gate_confirm[idx_q];
        busy        = 1'b1;
      end
      S_DONE: begin
        gate_done    = idx_onehot;
        gate_ok      = ok_q ? idx_onehot : '0;
        gate_timeout = to_q ? idx_onehot : '0;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  assign mgr_user_token = token_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: stimulus queues expected grants/completions, a monitor checks them.
module tb_gate_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] gate_req, gate_confirm;
  logic [11:0] gate_token;
  logic       mgr_valid, mgr_match;
  logic [3:0] gate_grant, gate_done, gate_ok, gate_timeout;
  logic       mgr_request, mgr_confirm, busy;
  logic [2:0] mgr_user_token;

  typedef struct { logic [3:0] grant; logic [2:0] token; } grant_t;
  typedef struct { logic [3:0] done; logic [3:0] ok; logic [3:0] to; } done_t;

  grant_t grant_q[$];
  done_t  done_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  logic [3:0] prev_grant = 4'b0;

  gate_arbiter #(.N_GATES(4), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .gate_req(gate_req), .gate_confirm(gate_confirm),
    .gate_token(gate_token), .mgr_valid(mgr_valid), .mgr_match(mgr_match),
    .gate_grant(gate_grant), .gate_done(gate_done), .gate_ok(gate_ok),
    .gate_timeout(gate_timeout), .mgr_request(mgr_request), .mgr_confirm(mgr_confirm),
    .mgr_user_token(mgr_user_token), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (gate_grant == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    if (gate_grant == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_grant no grant within 20 cycles");
    end
  endtask

  task automatic complete(input logic [3:0] mask, input logic match);
    done_t d;
    d.done = mask;
    d.ok   = match ? mask : 4'b0;
    d.to   = 4'b0;
    done_q.push_back(d);
    mgr_valid = 1'b1;
    mgr_match = match;
    tick();
    mgr_valid = 1'b0;
    mgr_match = 1'b0;
    chk("done_next_cycle", 32'(gate_done), 32'(mask));
  endtask

  task automatic push_grant(input logic [3:0] g, input logic [2:0] t);
    grant_t e;
    e.grant = g;
    e.token = t;
    grant_q.push_back(e);
  endtask

  // Monitor: compares every rising grant and every done pulse against the queues.
  always @(negedge clock) begin
    if (mon_en) begin
      grant_t ge;
      done_t  de;
      chk("req_matches_grant", 32'(mgr_request), 32'(gate_grant != 4'b0));
      if (gate_grant != 4'b0 && prev_grant == 4'b0) begin
        if (grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant got %b expected none", gate_grant);
        end else begin
          ge = grant_q.pop_front();
          chk("grant", 32'(gate_grant), 32'(ge.grant));
          chk("grant_token", 32'(mgr_user_token), 32'(ge.token));
        end
      end
      if (gate_done != 4'b0) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got %b expected none", gate_done);
        end else begin
          de = done_q.pop_front();
          chk("done", 32'(gate_done), 32'(de.done));
          chk("done_ok", 32'(gate_ok), 32'(de.ok));
          chk("done_timeout", 32'(gate_timeout), 32'(de.to));
        end
      end
      prev_grant <= gate_grant;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    gate_req = 4'b1111;
    gate_confirm = 4'b0;
    gate_token = {3'b111, 3'b101, 3'b110, 3'b011};
    mgr_valid = 1'b0;
    mgr_match = 1'b0;

    // Reset held 3 cycles with every gate requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en = 1;
      chk("reset_outputs", {gate_grant, gate_done, gate_ok, gate_timeout,
                            mgr_request, mgr_confirm, busy, mgr_user_token}, 32'd0);
    end
    push_grant(4'b0001, 3'b011);
    reset = 1'b0;
    tick();
    chk("first_grant_after_reset", 32'(gate_grant), 32'h1);
    gate_req = 4'b0001;
    complete(4'b0001, 1'b0);
    gate_req = 4'b0000;

    // Gate 2: confirm at grant+2, verdict at grant+4
    push_grant(4'b0100, 3'b101);
    gate_req = 4'b0100;
    wait_grant();
    tick();
    tick();
    gate_confirm = 4'b0100;
    #1;
    chk("mgr_confirm_fwd", 32'(mgr_confirm), 32'h1);
    tick();
    tick();
    complete(4'b0100, 1'b1);
    gate_confirm = 4'b0;
    gate_req = 4'b0000;

    // Gates 0 and 1 together, gate 0 re-requests: order 0, 1, 0
    push_grant(4'b0001, 3'b011);
    gate_req = 4'b0011;
    wait_grant();
    push_grant(4'b0010, 3'b110);
    complete(4'b0001, 1'b1);
    wait_grant();
    push_grant(4'b0001, 3'b011);
    complete(4'b0010, 1'b0);
    gate_req = 4'b0001;
    wait_grant();
    complete(4'b0001, 1'b1);
    gate_req = 4'b0000;

    // Verdict outside BUSY is ignored
    tick();
    mgr_valid = 1'b1;
    mgr_match = 1'b1;
    tick();
    mgr_valid = 1'b0;
    mgr_match = 1'b0;
    chk("idle_valid_no_busy", 32'(busy), 32'h0);
    tick();

    // Gate 1 aborts in the same cycle as a verdict
    push_grant(4'b0010, 3'b110);
    gate_req = 4'b0010;
    wait_grant();
    tick();
    gate_req = 4'b0000;
    mgr_valid = 1'b1;
    mgr_match = 1'b1;
    tick();
    mgr_valid = 1'b0;
    mgr_match = 1'b0;
    chk("abort_req_low", 32'(mgr_request), 32'h0);
    chk("abort_no_done", 32'(gate_done), 32'h0);
    tick();
    chk("abort_no_done_late", 32'(gate_done), 32'h0);

    // After abort of gate 1 the pointer is 2
    push_grant(4'b0100, 3'b101);
    gate_req = 4'b0111;
    wait_grant();
    tick();

    // Reset mid-BUSY discards the transaction and pointer returns to 0
    reset = 1'b1;
    push_grant(4'b0001, 3'b011);
    tick();
    chk("midbusy_reset_outputs", {gate_grant, gate_done, mgr_request, busy, mgr_user_token}, 32'd0);
    reset = 1'b0;
    wait_grant();
    chk("grant_after_midreset", 32'(gate_grant), 32'h1);
    complete(4'b0001, 1'b1);
    gate_req = 4'b0000;

`ifdef GATE_ARB_TIMEOUT_EN
    // Gate 3 never confirms: forced release TIMEOUT+1 = 5 cycles after grant
    begin
      done_t d;
      int n = 0;
      push_grant(4'b1000, 3'b111);
      d.done = 4'b1000; d.ok = 4'b0; d.to = 4'b1000;
      done_q.push_back(d);
      gate_req = 4'b1000;
      wait_grant();
      while (gate_done == 4'b0 && n < 20) begin
        tick();
        n++;
      end
      chk("timeout_latency", 32'(n), 32'd5);
      gate_req = 4'b0000;
    end
`else
    // Without the timeout a silent gate keeps its grant until the verdict
    push_grant(4'b1000, 3'b111);
    gate_req = 4'b1000;
    wait_grant();
    repeat (10) tick();
    chk("no_timeout_still_granted", 32'(gate_grant), 32'h8);
    complete(4'b1000, 1'b0);
    gate_req = 4'b0000;
`endif

    repeat (3) tick();
    chk("grant_queue_drained", 32'(grant_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
